// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline control for the five-stage Y86-64 core. Detects
//                load/use, ret and mispredict hazards, drives per-stage
//                stall/bubble controls, and sequences the run state
//                (INIT -> RUN -> DRAIN -> HALT). Performance counters are
//                built only when PIPE_CTRL_PERF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [3:0]       cpu_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [3:0] C_STAT_AOK = 4'h8;
    localparam logic [3:0] C_REG_NONE = 4'hF;
    localparam logic [3:0] C_I_NOP    = 4'h1;
    localparam logic [3:0] C_I_MRMOV  = 4'h5;
    localparam logic [3:0] C_I_OPQ    = 4'h6;
    localparam logic [3:0] C_I_JXX    = 4'h7;
    localparam logic [3:0] C_I_RET    = 4'h9;
    localparam logic [3:0] C_I_POPQ   = 4'hB;

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_halted;
    logic [3:0] r_cpu_stat;

    logic w_lu;
    logic w_rt;
    logic w_mp;
    logic w_m_exc;
    logic w_w_exc;
    logic w_ex;
    logic w_retire;
    logic w_any_bubble;

    // Hazard detection terms from the stage-register fields
    always_comb begin
        w_lu    = ((E_icode == C_I_MRMOV) || (E_icode == C_I_POPQ)) &&
                  (E_dstM != C_REG_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        w_rt    = (D_icode == C_I_RET) || (E_icode == C_I_RET) || (M_icode == C_I_RET);
        w_mp    = (E_icode == C_I_JXX) && !e_cnd;
        w_m_exc = (m_stat != C_STAT_AOK);
        w_w_exc = (W_stat != C_STAT_AOK);
        w_ex    = w_m_exc || w_w_exc;
    end

    // Pipe register controls; reset forces the INIT pattern immediately
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (rst || (r_state == S_INIT)) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (r_state == S_HALT) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            // RUN and DRAIN share the hazard logic; DRAIN keeps M bubbled
            // and never updates condition codes.
            F_stall  = w_lu || w_rt;
            D_stall  = w_lu;
            D_bubble = w_mp || (w_rt && !w_lu);
            E_bubble = w_mp || w_lu;
            W_stall  = w_w_exc;
            if (r_state == S_RUN) begin
                M_bubble = w_ex;
                set_cc   = (E_icode == C_I_OPQ) && !w_ex;
            end else begin
                M_bubble = 1'b1;
                set_cc   = 1'b0;
            end
        end
    end

    // Run-state sequencing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  w_state_nxt = S_RUN;
            S_RUN:   if (w_ex)    w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_w_exc) w_state_nxt = S_HALT;
            default: w_state_nxt = S_HALT;
        endcase
    end

    // State register, registered halt flag and latched processor status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_halted   <= 1'b0;
            r_cpu_stat <= C_STAT_AOK;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (r_state == S_HALT);
            if ((r_state != S_HALT) && (w_state_nxt == S_HALT)) begin
                r_cpu_stat <= W_stat;
            end
        end
    end

    assign halted   = r_halted;
    assign cpu_stat = r_cpu_stat;

    assign w_retire     = (W_stat == C_STAT_AOK) && (W_icode != C_I_NOP);
    assign w_any_bubble = D_bubble || E_bubble;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_cnt_en;

    assign w_cnt_en = (r_state == S_RUN) || (r_state == S_DRAIN);

    // Saturating performance counters, active only while running or draining
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_bubble_cnt <= '0;
        end else if (w_cnt_en) begin
            if (r_cycle_cnt != '1) begin
                r_cycle_cnt <= r_cycle_cnt + C_CNT_ONE;
            end
            if (w_retire && (r_retire_cnt != '1)) begin
                r_retire_cnt <= r_retire_cnt + C_CNT_ONE;
            end
            if (w_any_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
            end
        end
    end

    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    // Counter qualifiers have no load without the counters
    logic w_unused_perf;
    assign w_unused_perf = w_retire ^ w_any_bubble;

    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking scoreboard bench for pipe_ctrl, with a second
//                narrow-counter instance for saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    localparam logic [6:0] E_INIT = 7'b1011100;
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_LU   = 7'b1101000;
    localparam logic [6:0] E_RT   = 7'b1010000;
    localparam logic [6:0] E_RTLU = 7'b1101000;
    localparam logic [6:0] E_MP   = 7'b0011000;
    localparam logic [6:0] E_MPRT = 7'b1011000;
    localparam logic [6:0] E_CC   = 7'b0000001;
    localparam logic [6:0] E_EXC  = 7'b0000100;
    localparam logic [6:0] E_DRN  = 7'b0000110;
    localparam logic [6:0] E_HALT = 7'b1101110;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;
    logic       e_cnd;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [3:0]  cpu_stat;
    logic [31:0] cycle_cnt, retire_cnt, bubble_cnt;

    logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc, s_halted;
    logic [3:0]  s_cpu_stat;
    logic [3:0]  s_cycle_cnt, s_retire_cnt, s_bubble_cnt;

    logic [6:0]  ctrl;
    assign ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

    int n_cmp = 0;
    int n_mis = 0;
    logic [6:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
        .cpu_stat(cpu_stat), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_dut_small (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble),
        .M_bubble(s_M_bubble), .W_stall(s_W_stall), .set_cc(s_set_cc), .halted(s_halted),
        .cpu_stat(s_cpu_stat), .cycle_cnt(s_cycle_cnt), .retire_cnt(s_retire_cnt), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_cnd = 1'b1;
        M_icode = 4'h1; m_stat = 4'h8;
        W_icode = 4'h1; W_stat = 4'h8;
    endtask

    // Inputs are already driven; queue the expected controls, compare on the
    // falling edge, then advance to just past the next rising edge.
    task automatic apply(input string tag, input logic [6:0] exp);
        sb_q.push_back(exp);
        @(negedge clk);
        chk(tag, {25'd0, ctrl}, {25'd0, sb_q.pop_front()});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pexp(input int v);
        return PERF ? v : 0;
    endfunction

    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cpu_stat", {28'd0, cpu_stat}, 32'h8);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        chk("rst_bubble_cnt", bubble_cnt, 32'd0);
        apply("rst_ctrl", E_INIT);
        rst = 1'b0;
        apply("init", E_INIT);
        apply("run_idle", E_NONE);
        chk("run_cpu_stat", {28'd0, cpu_stat}, 32'h8);

        // load/use
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        apply("lu_srcB", E_LU);
        E_dstM = 4'hF;
        apply("lu_dst_none", E_NONE);
        E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4; d_srcB = 4'hF;
        apply("lu_pop_srcA", E_LU);
        set_idle();

        // ret walking D -> E -> M, then ret combined with load/use
        D_icode = 4'h9;
        apply("rt_D", E_RT);
        D_icode = 4'h1; E_icode = 4'h9;
        apply("rt_E", E_RT);
        E_icode = 4'h1; M_icode = 4'h9;
        apply("rt_M", E_RT);
        M_icode = 4'h1; D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        apply("rt_lu", E_RTLU);
        set_idle();

        // mispredict
        E_icode = 4'h7; e_cnd = 1'b0;
        apply("mp", E_MP);
        D_icode = 4'h9;
        apply("mp_rt", E_MPRT);
        D_icode = 4'h1; e_cnd = 1'b1;
        apply("jxx_taken", E_NONE);
        set_idle();

        // condition codes, then exception drain to halt
        E_icode = 4'h6;
        apply("opq_cc", E_CC);
        m_stat = 4'h2;
        apply("exc_m", E_EXC);
        m_stat = 4'h8; W_stat = 4'h2;
        apply("drain", E_DRN);
        chk("halt_cpu_stat", {28'd0, cpu_stat}, 32'h2);
        chk("halt_entry_halted", {31'd0, halted}, 32'd0);
        apply("halt0", E_HALT);
        chk("halted_late", {31'd0, halted}, 32'd1);
        set_idle();
        apply("halt1", E_HALT);
        chk("halt_cpu_stat_hold", {28'd0, cpu_stat}, 32'h2);
        rst = 1'b1;
        apply("rst_in_halt", E_INIT);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_cpu_stat", {28'd0, cpu_stat}, 32'h8);
        rst = 1'b0;
        apply("init2", E_INIT);

        // counters: 10 RUN cycles, 4 retiring, 2 mispredicting
        for (int i = 0; i < 10; i++) begin
            set_idle();
            if (i < 4) W_icode = 4'h2;
            if (i == 5 || i == 6) begin
                E_icode = 4'h7; e_cnd = 1'b0;
            end
            apply("perf_run", (i == 5 || i == 6) ? E_MP : E_NONE);
        end
        chk("cycle_cnt_10", cycle_cnt, pexp(10));
        chk("retire_cnt_4", retire_cnt, pexp(4));
        chk("bubble_cnt_2", bubble_cnt, pexp(2));
        set_idle();
        for (int i = 0; i < 6; i++) apply("perf_idle", E_NONE);
        chk("cycle_cnt_16", cycle_cnt, pexp(16));
        chk("small_cycle_sat", {28'd0, s_cycle_cnt}, pexp(15));
        chk("small_retire", {28'd0, s_retire_cnt}, pexp(4));
        chk("small_bubble", {28'd0, s_bubble_cnt}, pexp(2));

        // writeback exception together with ex in RUN
        W_stat = 4'h4;
        apply("exc_w_run", E_DRN);
        apply("exc_w_drain", E_DRN);
        chk("halt_w_cpu_stat", {28'd0, cpu_stat}, 32'h4);
        apply("halt_w", E_HALT);
        apply("halt_w2", E_HALT);
        chk("cycle_cnt_frozen", cycle_cnt, pexp(18));
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
